// File: rtl/uart_io_pio_gpio.sv
// Avalon-MM GPIO/PIO peripheral: synchronised inputs with edge capture and a
// masked level interrupt, plus per-bit direction, set/clear and blink outputs.
module uart_io_pio_gpio #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned BLINK_W     = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 1);

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_DIR       = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR    = 3'd5;
    localparam logic [2:0] ADDR_BLINKMASK = 3'd6;
    localparam logic [2:0] ADDR_BLINKPER  = 3'd7;

    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic [WIDTH-1:0]   dir_q, dir_d;
    logic [WIDTH-1:0]   irqmask_q, irqmask_d;
    logic [WIDTH-1:0]   edgecap_q, edgecap_d;
    logic [WIDTH-1:0]   blinkmask_q, blinkmask_d;
    logic [BLINK_W-1:0] blinkper_q, blinkper_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
    logic               armed_q, armed_d;
    logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   sync_d [SYNC_STAGES];
    logic [WIDTH-1:0]   prev_q, prev_d;

    logic               wr_en;
    logic [WIDTH-1:0]   wdata_w;
    logic [WIDTH-1:0]   sync_in;
    logic [WIDTH-1:0]   edge_sel;
    logic [WIDTH-1:0]   edge_det;
    logic               unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata_w      = writedata[WIDTH-1:0];
    assign sync_in      = sync_q[SYNC_STAGES-1];
    // Upper writedata bits are intentionally ignored for narrow configurations.
    assign unused_wdata = ^writedata;

    // Input synchroniser chain and one-cycle delayed copy for edge detection.
    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        // prev follows sync_in whatever the direction, so turning a pin into
        // an input later never produces a stale-edge capture.
        prev_d = sync_in;
    end

    // Select the configured edge kind, then gate by input direction and arming.
    always_comb begin
        case (EDGE_TYPE)
            0:       edge_sel = sync_in & ~prev_q;
            1:       edge_sel = ~sync_in & prev_q;
            default: edge_sel = sync_in ^ prev_q;
        endcase
        edge_det = edge_sel & ~dir_q & {WIDTH{armed_q}};
    end

    // Arm counter: hold off capture until the synchroniser has flushed after reset.
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        if (!armed_q) begin
            if (arm_cnt_q == ARM_W'(SYNC_STAGES)) begin
                armed_d = 1'b1;
            end else begin
                arm_cnt_d = arm_cnt_q + ARM_W'(1);
            end
        end
    end

    // Register file writes and edge-capture update.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned; a missing default infers a latch.
        data_out_d  = data_out_q;
        dir_d       = dir_q;
        irqmask_d   = irqmask_q;
        blinkmask_d = blinkmask_q;
        blinkper_d  = blinkper_q;
        edgecap_d   = edgecap_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:      data_out_d  = wdata_w;
                ADDR_DIR:       dir_d       = wdata_w;
                ADDR_IRQMASK:   irqmask_d   = wdata_w;
                ADDR_EDGECAP:   edgecap_d   = edgecap_q & ~wdata_w;
                ADDR_OUTSET:    data_out_d  = data_out_q | wdata_w;
                ADDR_OUTCLR:    data_out_d  = data_out_q & ~wdata_w;
                ADDR_BLINKMASK: blinkmask_d = wdata_w;
                ADDR_BLINKPER:  blinkper_d  = BLINK_W'(writedata);
                default:        ;
            endcase
        end
        // Applied after the clear so a new edge wins over a same-cycle W1C.
        edgecap_d = edgecap_d | edge_det;
    end

    // Blink counter: half-period of BLINKPER+1 cycles, frozen at zero when idle.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (wr_en && address == ADDR_BLINKPER) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blinkper_q == '0) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == blinkper_q) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            data_out_q    <= RESET_VALUE;
            dir_q         <= '0;
            irqmask_q     <= '0;
            edgecap_q     <= '0;
            blinkmask_q   <= '0;
            blinkper_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            arm_cnt_q     <= '0;
            armed_q       <= 1'b0;
            prev_q        <= '0;
            // NOTE: the synchroniser array is reset element by element; it is a
            // handful of flops, not a RAM, and must not carry an edge across reset.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            data_out_q    <= data_out_d;
            dir_q         <= dir_d;
            irqmask_q     <= irqmask_d;
            edgecap_q     <= edgecap_d;
            blinkmask_q   <= blinkmask_d;
            blinkper_q    <= blinkper_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            arm_cnt_q     <= arm_cnt_d;
            armed_q       <= armed_d;
            prev_q        <= prev_d;
            sync_q        <= sync_d;
        end
    end

    // Zero-latency read mux; DATA mixes driven values and synchronised pins.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata = 32'((data_out_q & dir_q) | (sync_in & ~dir_q));
            ADDR_DIR:       readdata = 32'(dir_q);
            ADDR_IRQMASK:   readdata = 32'(irqmask_q);
            ADDR_EDGECAP:   readdata = 32'(edgecap_q);
            ADDR_BLINKMASK: readdata = 32'(blinkmask_q);
            ADDR_BLINKPER:  readdata = 32'(blinkper_q);
            default:        readdata = '0;
        endcase
    end

    assign oe_port  = dir_q;
    assign out_port = data_out_q ^ (blinkmask_q & {WIDTH{blink_phase_q}});
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_uart_io_pio_gpio.sv
// Directed self-checking bench for uart_io_pio_gpio with an expected-value queue.
module tb_uart_io_pio_gpio;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic [WIDTH-1:0] out_port;
    logic [WIDTH-1:0] oe_port;
    logic             irq;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    uart_io_pio_gpio #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(8'h00),
        .EDGE_TYPE  (0),
        .SYNC_STAGES(2),
        .BLINK_W    (24)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .oe_port   (oe_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%h expected=<none>", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === e.value) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, observed, e.value);
            end
        end
    endtask

    // Single bus write; returns #1 after the edge that commits it.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = readdata;
    endtask

    initial begin
        logic [31:0] r;

        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        push_exp("reset_out_port", 32'h0);  check(32'(out_port));
        push_exp("reset_oe_port", 32'h0);   check(32'(oe_port));
        push_exp("reset_irq", 32'h0);       check(32'(irq));
        reset_n = 1'b1;

        // Output set/clear
        wr(3'd1, 32'hFF);
        wr(3'd4, 32'h0F);
        wr(3'd5, 32'h03);
        @(negedge clk);
        push_exp("out_port_set_clr", 32'h0C); check(32'(out_port));
        push_exp("oe_port_dir", 32'hFF);      check(32'(oe_port));
        rd(3'd0, r); push_exp("read_data_out", 32'h0C); check(r);
        rd(3'd4, r); push_exp("read_outset_zero", 32'h0); check(r);

        // Rising edge capture latency and W1C
        wr(3'd1, 32'h00);
        wr(3'd2, 32'h01);
        @(posedge clk);
        #1 in_port = 8'h01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        address = 3'd3;
        #1;
        push_exp("edgecap_before_latency", 32'h0); check(readdata);
        @(posedge clk);
        @(negedge clk);
        #1;
        push_exp("edgecap_at_latency", 32'h01); check(readdata);
        push_exp("irq_set", 32'h1);             check(32'(irq));
        wr(3'd3, 32'h01);
        push_exp("irq_after_w1c", 32'h0);       check(32'(irq));

        // Edge and W1C on the same bit in the same cycle: set wins
        @(posedge clk);
        #1 in_port = 8'h05;
        repeat (2) @(posedge clk);
        wr(3'd3, 32'h04);
        rd(3'd3, r); push_exp("edge_beats_w1c", 32'h04); check(r);
        wr(3'd3, 32'h04);
        rd(3'd3, r); push_exp("w1c_clears", 32'h0); check(r);

        // Output-direction pins never capture; turning them to inputs does not either
        wr(3'd1, 32'h02);
        @(posedge clk);
        #1 in_port = 8'h07;
        repeat (5) @(posedge clk);
        rd(3'd3, r); push_exp("no_capture_dir_out", 32'h0); check(r);
        wr(3'd1, 32'h00);
        repeat (5) @(posedge clk);
        rd(3'd3, r); push_exp("no_capture_dir_1to0", 32'h0); check(r);
        rd(3'd0, r); push_exp("read_data_sync_in", 32'h07); check(r);

        // Pins high through reset release must not capture
        @(negedge clk);
        in_port = 8'hFF;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        address = 3'd3;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            push_exp("no_capture_after_reset", 32'h0); check(readdata);
        end

        // Blink with BLINKPER=3: out_port[0] toggles every 4 cycles
        wr(3'd1, 32'hFF);
        wr(3'd6, 32'h01);
        wr(3'd7, 32'h3);
        push_exp("blink_start", 32'h0); check(32'(out_port));
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            push_exp("blink_phase", 32'((k / 4) % 2)); check(32'(out_port));
        end
        wr(3'd7, 32'h0);
        for (int k = 0; k < 6; k++) begin
            push_exp("blink_stopped", 32'h0); check(32'(out_port));
            @(posedge clk);
            #1;
        end

        // Reset mid-blink with captured edges pending
        @(negedge clk);
        in_port = 8'h00;
        wr(3'd1, 32'h00);
        wr(3'd2, 32'h05);
        wr(3'd7, 32'h2);
        @(posedge clk);
        #1 in_port = 8'h05;
        repeat (5) @(posedge clk);
        rd(3'd3, r); push_exp("edgecap_before_reset", 32'h05); check(r);
        push_exp("irq_before_reset", 32'h1); check(32'(irq));
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        push_exp("post_reset_out_port", 32'h0); check(32'(out_port));
        push_exp("post_reset_oe_port", 32'h0);  check(32'(oe_port));
        push_exp("post_reset_irq", 32'h0);      check(32'(irq));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        rd(3'd3, r); push_exp("no_residual_edge", 32'h0); check(r);
        rd(3'd7, r); push_exp("blinkper_cleared", 32'h0); check(r);
        push_exp("irq_stays_low", 32'h0); check(32'(irq));

        if (sb_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_io_pio_gpio.md
UART_IO_PIO_GPIO -- requirements
Module: uart_io_pio_gpio

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of GPIO bits, legal range 1..32.
REQ-002 SHALL have parameter RESET_VALUE, default 0: reset value of the output data register.
REQ-003 SHALL have parameter EDGE_TYPE, default 0: edge that is captured; 0 = rising, 1 = falling, 2 = any.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: depth of the input synchroniser, legal range 2..4.
REQ-005 SHALL have parameter BLINK_W, default 24: width of the blink period register and blink counter.
REQ-006 Clock and reset (already decided): one clock, clk; reset is synchronous and active-low, reset_n; no asynchronous reset path.
REQ-007 Port clk, input, 1: sole clock; all state on rising edge.
REQ-008 Port reset_n, input, 1: synchronous active-low reset.
REQ-009 Port address, input, 3: Avalon-MM slave word address.
REQ-010 Port chipselect, input, 1: slave select.
REQ-011 Port write_n, input, 1: active-low write strobe.
REQ-012 Port writedata, input, 32: write data; bits above WIDTH ignored.
REQ-013 Port readdata, output, 32: read data; bits above WIDTH read 0.
REQ-014 Port in_port, input, WIDTH: asynchronous pin inputs.
REQ-015 Port out_port, output, WIDTH: pin output values.
REQ-016 Port oe_port, output, WIDTH: per-bit output enable; 1 = driven.
REQ-017 Port irq, output, 1: active-high level interrupt.

Function
REQ-018 Write strobe SHALL be chipselect=1 and write_n=0; writes take effect at the next clk edge.
REQ-019 Register map SHALL be as follows.
- 0 DATA: write loads data_out; read returns data_out for bits with dir=1 and sync_in for bits with dir=0.
- 1 DIR: read/write; 1 = output.
- 2 IRQMASK: read/write.
- 3 EDGECAP: read; write-1-to-clear.
- 4 OUTSET: write sets data_out bits; reads 0.
- 5 OUTCLR: write clears data_out bits; reads 0.
- 6 BLINKMASK: read/write.
- 7 BLINKPER: read/write, BLINK_W bits.
REQ-020 readdata SHALL be zero-latency combinational from address, independent of chipselect.
REQ-021 oe_port SHALL equal DIR.
REQ-022 out_port SHALL equal data_out XOR (BLINKMASK AND replicated blink_phase).
REQ-023 in_port SHALL pass through a SYNC_STAGES flop chain to give sync_in; a prev register SHALL hold sync_in delayed by one cycle.
REQ-024 An edge on a bit SHALL be detected only on that bit's sync_in versus prev, according to EDGE_TYPE, and only when dir=0 and armed=1.
REQ-025 For a detected edge, the EDGECAP bit SHALL set at the next clk edge.
- Latency from an in_port change to EDGECAP set: SYNC_STAGES+1 edges.
REQ-026 When an edge and a W1C write hit the same bit in the same cycle, set SHALL win.
REQ-027 irq SHALL equal the OR-reduction of (EDGECAP AND IRQMASK), combinational from registers.
REQ-028 Arm counter behaviour:
- armed=0 after reset.
- The counter counts SYNC_STAGES+1 cycles, then armed=1 and stays 1.
- This suppresses spurious edges from pins already high at reset release.
REQ-029 Blink counter behaviour:
- When BLINKPER=0, counter and blink_phase SHALL be held at 0.
- Otherwise the counter increments each cycle.
- When the counter equals BLINKPER, it wraps to 0 and blink_phase toggles.
- Half-period is BLINKPER+1 cycles.
REQ-030 A write to BLINKPER SHALL clear the counter and blink_phase in the same edge.
REQ-031 A write to DIR changing a bit from 1 to 0 SHALL NOT itself cause an edge capture.
- prev continues tracking sync_in regardless of dir.

Reset
REQ-032 With reset_n=0 at a clk edge, state SHALL reset as follows:
- data_out=RESET_VALUE.
- DIR, IRQMASK, EDGECAP, BLINKMASK, BLINKPER = 0.
- Blink counter, blink_phase, arm counter, armed, sync chain and prev = 0.
REQ-033 During and after reset:
- out_port=RESET_VALUE, oe_port=0, irq=0.
- Reset mid-blink or mid-capture SHALL abandon all state with no residual edge.

Verification
REQ-034 Reset then write DIR=0xFF, OUTSET 0x0F, OUTCLR 0x03 -> out_port=0x0C, read DATA=0x0C.
REQ-035 DIR=0, EDGE_TYPE=0, IRQMASK=0x01, in_port[0] 0->1 -> EDGECAP=0x01 exactly 3 edges later, irq=1; write EDGECAP 0x01 -> irq=0 next cycle.
REQ-036 Edge on bit 2 in the same cycle as W1C 0x04 -> EDGECAP[2] remains 1.
REQ-037 in_port=0xFF held through reset release -> EDGECAP stays 0x00 for 20 cycles.
REQ-038 DIR=0xFF, data_out=0, BLINKMASK=0x01, BLINKPER=3 -> out_port[0] toggles every 4 cycles; write BLINKPER=0 -> out_port[0]=0 held.
REQ-039 Assert reset_n=0 for one edge mid-blink with EDGECAP=0x05 -> all outputs at reset values next cycle, irq=0.
